// File: rtl/frost32_mem_bridge_if.sv
// Bus bundle between the CPU-side load/store port, the bridge and an 8-bit synchronous RAM.
//   cpu_*  : single-request word/half/byte access port (request, address, data, type, size,
//            read result, busy, done pulse)
//   mem_*  : byte-wide RAM port (address, write strobe, write byte, read byte one cycle later)
// Modports: master = CPU + RAM environment, slave = bridge.
interface frost32_mem_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  cpu_req;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wr_data;
  logic                  cpu_access_type;
  logic [1:0]            cpu_access_size;
  logic [31:0]           cpu_rd_data;
  logic                  cpu_busy;
  logic                  cpu_done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wr_en;
  logic [7:0]            mem_wr_data;
  logic [7:0]            mem_rd_data;

  modport master (
    output cpu_req, cpu_addr, cpu_wr_data, cpu_access_type, cpu_access_size, mem_rd_data,
    input  cpu_rd_data, cpu_busy, cpu_done, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wr_data, cpu_access_type, cpu_access_size, mem_rd_data,
    output cpu_rd_data, cpu_busy, cpu_done, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/frost32_mem_bridge.sv
// Bridges a 32/16/8-bit CPU load/store request onto an 8-bit synchronous RAM, one byte per
// cycle, big-endian, with address wrap at ADDR_WIDTH bits. All outputs are registered.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : frost32_mem_bridge_if.slave (CPU request/response and byte RAM port)
module frost32_mem_bridge #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frost32_mem_bridge_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;     // cycle index within READ/WRITE, starts at 1
  logic [2:0]            n_q, n_d;         // bytes in this access
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           sh_q, sh_d;       // write data left-aligned, next byte in [31:24]
  logic [31:0]           acc_q, acc_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [7:0]            wr_data_q, wr_data_d;

  logic [2:0]            n_new;
  logic [31:0]           aligned;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Size decode; reserved size 3 behaves as a full word.
  always_comb begin
    n_new   = 3'd4;
    aligned = bus.cpu_wr_data;
    unique case (bus.cpu_access_size)
      2'd1:    begin n_new = 3'd2; aligned = bus.cpu_wr_data << 16; end
      2'd2:    begin n_new = 3'd1; aligned = bus.cpu_wr_data << 24; end
      default: begin n_new = 3'd4; aligned = bus.cpu_wr_data;       end
    endcase
  end

  // Truncating add gives the modulo-2^ADDR_WIDTH wrap for free.
  assign next_addr = base_q + ADDR_WIDTH'(cnt_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    base_d     = base_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_addr_d = mem_addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          n_d        = n_new;
          base_d     = bus.cpu_addr[ADDR_WIDTH-1:0];
          mem_addr_d = bus.cpu_addr[ADDR_WIDTH-1:0];
          cnt_d      = 3'd1;
          busy_d     = 1'b1;
          acc_d      = '0;
          if (bus.cpu_access_type) begin
            state_d   = StWrite;
            wr_en_d   = 1'b1;
            wr_data_d = aligned[31:24];
            sh_d      = aligned << 8;
          end else begin
            state_d   = StRead;
          end
        end
      end

      StWrite: begin
        if (cnt_q < n_q) begin
          wr_en_d    = 1'b1;
          mem_addr_d = next_addr;
          wr_data_d  = sh_q[31:24];
          sh_d       = sh_q << 8;
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end

      StRead: begin
        // Address leads data by one cycle, so the shift starts in cycle 2.
        if (cnt_q < n_q) begin
          mem_addr_d = next_addr;
        end
        if (cnt_q >= 3'd2) begin
          acc_d = {acc_q[23:0], bus.mem_rd_data};
        end
        if (cnt_q == n_q + 3'd1) begin
          rd_data_d = {acc_q[23:0], bus.mem_rd_data};
          state_d   = StDone;
          done_d    = 1'b1;
        end
        cnt_d = cnt_q + 3'd1;
      end

      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      n_q        <= '0;
      base_q     <= '0;
      sh_q       <= '0;
      acc_q      <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      base_q     <= base_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      rd_data_q  <= rd_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.cpu_rd_data = rd_data_q;
  assign bus.cpu_busy    = busy_q;
  assign bus.cpu_done    = done_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;

endmodule

// File: tb/tb_frost32_mem_bridge.sv
// Self-checking bench for frost32_mem_bridge: directed scenarios plus randomized accesses
// checked against a byte-array memory model.
module tb_frost32_mem_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frost32_mem_bridge_if #(.ADDR_WIDTH(16)) bus ();

  frost32_mem_bridge #(.ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment: byte-wide synchronous RAM.
  logic [7:0] ram [0:65535];
  logic [7:0] ram_rd;
  always @(posedge clk) begin
    if (bus.mem_wr_en === 1'b1) ram[bus.mem_addr] <= bus.mem_wr_data;
    ram_rd <= ram[bus.mem_addr];
  end
  assign bus.mem_rd_data = ram_rd;

  // Reference memory image and observations.
  logic [7:0]  ref_mem [0:65535];
  logic [23:0] wq[$];   // {addr, data} of every write strobe seen
  logic [15:0] aq[$];   // mem_addr in each cycle of an access
  logic [31:0] last_rd;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) if (bus.mem_wr_en === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wr_data});

  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd1:    return 2;
      2'd2:    return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v = 0;
    for (int i = 0; i < nbytes(s); i++) v = (v << 8) | 32'(ref_mem[16'(a + 32'(i))]);
    return v;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] d, input logic [1:0] s, input int k);
    logic [31:0] t;
    t = d >> (8 * (nbytes(s) - 1 - k));
    return t[7:0];
  endfunction

  // Drive one access from an idle negedge; returns latency, read result and protocol shape.
  task automatic drive(input bit typ, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                       output bit shape_ok);
    wq.delete();
    aq.delete();
    bus.cpu_req = 1'b1;
    bus.cpu_access_type = typ;
    bus.cpu_access_size = size;
    bus.cpu_addr = addr;
    bus.cpu_wr_data = wdata;
    @(posedge clk);
    lat = -1;
    shape_ok = 1'b1;
    rdata = 32'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.cpu_req = 1'b0;
        bus.cpu_access_type = 1'($urandom);
        bus.cpu_access_size = 2'($urandom);
        bus.cpu_addr = $urandom;
        bus.cpu_wr_data = $urandom;
      end
      aq.push_back(bus.mem_addr);
      if (bus.cpu_busy !== 1'b1) shape_ok = 1'b0;
      if (!typ && bus.mem_wr_en !== 1'b0) shape_ok = 1'b0;
      if (bus.cpu_done === 1'b1) begin
        lat = k;
        rdata = bus.cpu_rd_data;
        break;
      end
    end
    @(negedge clk);
    if (bus.cpu_done !== 1'b0 || bus.cpu_busy !== 1'b0) shape_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    // Request asserted together with reset must not start anything.
    bus.cpu_req = 1'b1;
    bus.cpu_access_type = 1'b1;
    bus.cpu_access_size = 2'd0;
    bus.cpu_addr = 32'h0000_1234;
    bus.cpu_wr_data = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    checks++; if (bus.cpu_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", bus.cpu_rd_data); end
    checks++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.cpu_busy); end
    checks++; if (bus.cpu_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.cpu_done); end
    checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.mem_wr_en); end
    checks++; if (bus.mem_wr_data !== 8'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", bus.mem_wr_data); end
    bus.cpu_req = 1'b0;
    rst_n = 1'b1;
    last_rd = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_read32;
    int lat; logic [31:0] rd; bit ok;
    drive(1'b0, 2'd0, 32'hABCD_0100, 32'h0, lat, rd, ok);
    checks++; if (lat !== 6) begin errors++; $display("FAIL read32_latency: got %0d want 6", lat); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read32_data: got %h want 12345678", rd); end
    checks++; if (!ok) begin errors++; $display("FAIL read32_shape: got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (aq[i] !== 16'(16'h0100 + i)) begin
        errors++; $display("FAIL read32_addr%0d: got %h want %h", i, aq[i], 16'(16'h0100 + i));
      end
    end
    checks++; if (wq.size() != 0) begin errors++; $display("FAIL read32_no_write: got %0d want 0", wq.size()); end
    last_rd = 32'h1234_5678;
  endtask

  task automatic test_write_wrap;
    int lat; logic [31:0] rd; bit ok;
    drive(1'b1, 2'd0, 32'h0000_FFFE, 32'hDEAD_BEEF, lat, rd, ok);
    checks++; if (lat !== 5) begin errors++; $display("FAIL write32_latency: got %0d want 5", lat); end
    checks++; if (!ok) begin errors++; $display("FAIL write32_shape: got 0 want 1"); end
    checks++; if (rd !== last_rd) begin errors++; $display("FAIL write32_rd_hold: got %h want %h", rd, last_rd); end
    checks++; if (wq.size() != 4) begin errors++; $display("FAIL write32_strobes: got %0d want 4", wq.size()); end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {16'(16'hFFFE + i), ref_byte(32'hDEAD_BEEF, 2'd0, i)}) begin
        errors++; $display("FAIL write32_strobe%0d: got %h want %h", i, wq[i],
                           {16'(16'hFFFE + i), ref_byte(32'hDEAD_BEEF, 2'd0, i)});
      end
    end
    for (int i = 0; i < 4; i++) ref_mem[16'(16'hFFFE + i)] = ref_byte(32'hDEAD_BEEF, 2'd0, i);
    drive(1'b0, 2'd0, 32'h0000_FFFE, 32'h0, lat, rd, ok);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write32_readback: got %h want deadbeef", rd); end
    last_rd = rd;
  endtask

  task automatic test_small_sizes;
    int lat; logic [31:0] rd; bit ok;
    drive(1'b0, 2'd1, 32'h0000_0102, 32'h0, lat, rd, ok);
    checks++; if (lat !== 4) begin errors++; $display("FAIL read16_latency: got %0d want 4", lat); end
    checks++; if (rd !== 32'h0000_5678) begin errors++; $display("FAIL read16_data: got %h want 00005678", rd); end
    last_rd = 32'h0000_5678;
    drive(1'b1, 2'd2, 32'h0000_0010, 32'h0000_00A5, lat, rd, ok);
    checks++; if (lat !== 2) begin errors++; $display("FAIL write8_latency: got %0d want 2", lat); end
    checks++; if (wq.size() != 1 || wq[0] !== 24'h0010A5) begin
      errors++; $display("FAIL write8_strobe: got %0d strobes first %h want 1 strobe 0010a5", wq.size(), (wq.size() > 0) ? wq[0] : 24'h0);
    end
    checks++; if (ram[16'h0010] !== 8'hA5) begin errors++; $display("FAIL write8_ram: got %h want a5", ram[16'h0010]); end
    ref_mem[16'h0010] = 8'hA5;
    drive(1'b0, 2'd3, 32'h0000_0100, 32'h0, lat, rd, ok);
    checks++; if (lat !== 6 || rd !== 32'h1234_5678) begin
      errors++; $display("FAIL reserved_size: got lat %0d data %h want lat 6 data 12345678", lat, rd);
    end
    last_rd = 32'h1234_5678;
  endtask

  task automatic test_held_req;
    int lat;
    aq.delete();
    bus.cpu_req = 1'b1;
    bus.cpu_access_type = 1'b0;
    bus.cpu_access_size = 2'd0;
    bus.cpu_addr = 32'h0000_0100;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      aq.push_back(bus.mem_addr);
      bus.cpu_addr = $urandom;
      checks++; if (bus.cpu_busy !== 1'b1 || bus.cpu_done !== (k == 6)) begin
        errors++; $display("FAIL held_cycle%0d: got busy %b done %b want busy 1 done %b", k, bus.cpu_busy, bus.cpu_done, k == 6);
      end
    end
    checks++; if (bus.cpu_rd_data !== 32'h1234_5678) begin errors++; $display("FAIL held_data: got %h want 12345678", bus.cpu_rd_data); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (aq[i] !== 16'(16'h0100 + i)) begin errors++; $display("FAIL held_addr%0d: got %h want %h", i, aq[i], 16'(16'h0100 + i)); end
    end
    @(negedge clk);
    checks++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL held_idle: got busy %b want 0", bus.cpu_busy); end
    bus.cpu_addr = 32'h0000_0103;
    bus.cpu_access_size = 2'd2;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    checks++; if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL held_accept: got busy %b want 1", bus.cpu_busy); end
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      if (bus.cpu_done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    checks++; if (lat !== 3 || bus.cpu_rd_data !== 32'h0000_0078) begin
      errors++; $display("FAIL held_second: got lat %0d data %h want lat 3 data 00000078", lat, bus.cpu_rd_data);
    end
    last_rd = 32'h0000_0078;
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [31:0] d;
    bit bad;
    d = $urandom;
    wq.delete();
    bus.cpu_req = 1'b1;
    bus.cpu_access_type = 1'b1;
    bus.cpu_access_size = 2'd0;
    bus.cpu_addr = 32'h0000_0200;
    bus.cpu_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({bus.cpu_rd_data, bus.cpu_busy, bus.cpu_done, bus.mem_addr, bus.mem_wr_en, bus.mem_wr_data} !== 59'h0) begin
      errors++; $display("FAIL abort_outputs: got rd %h busy %b done %b addr %h we %b wd %h want all 0",
                         bus.cpu_rd_data, bus.cpu_busy, bus.cpu_done, bus.mem_addr, bus.mem_wr_en, bus.mem_wr_data);
    end
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.cpu_done !== 1'b0 || bus.mem_wr_en !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad) begin errors++; $display("FAIL abort_quiet: got done/wr_en activity want none"); end
    ref_mem[16'h0200] = d[31:24];
    checks++; if (wq.size() != 1) begin errors++; $display("FAIL abort_strobes: got %0d want 1", wq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram[16'(16'h0200 + i)] !== ref_mem[16'(16'h0200 + i)]) begin
        errors++; $display("FAIL abort_ram%0d: got %h want %h", i, ram[16'(16'h0200 + i)], ref_mem[16'(16'h0200 + i)]);
      end
    end
    last_rd = 32'h0;
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd; bit ok;
    bit typ; logic [1:0] sz; logic [31:0] a, d;
    int n;
    for (int t = 0; t < 40; t++) begin
      typ = 1'($urandom);
      sz = 2'($urandom);
      a = {16'($urandom), 16'(16'hFFF8 + $urandom_range(0, 15))};
      d = $urandom;
      n = nbytes(sz);
      drive(typ, sz, a, d, lat, rd, ok);
      checks++; if (lat !== (typ ? n + 1 : n + 2) || !ok) begin
        errors++; $display("FAIL rand%0d_timing: got lat %0d shape %b want lat %0d shape 1", t, lat, ok, typ ? n + 1 : n + 2);
      end
      if (typ) begin
        checks++; if (rd !== last_rd) begin errors++; $display("FAIL rand%0d_rd_hold: got %h want %h", t, rd, last_rd); end
        checks++; if (wq.size() != n) begin errors++; $display("FAIL rand%0d_nstrobe: got %0d want %0d", t, wq.size(), n); end
        for (int i = 0; i < n && i < wq.size(); i++) begin
          checks++;
          if (wq[i] !== {16'(a + 32'(i)), ref_byte(d, sz, i)}) begin
            errors++; $display("FAIL rand%0d_strobe%0d: got %h want %h", t, i, wq[i], {16'(a + 32'(i)), ref_byte(d, sz, i)});
          end
        end
        for (int i = 0; i < n; i++) ref_mem[16'(a + 32'(i))] = ref_byte(d, sz, i);
      end else begin
        checks++; if (rd !== ref_read(a, sz)) begin errors++; $display("FAIL rand%0d_read: got %h want %h", t, rd, ref_read(a, sz)); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rand%0d_read_strobe: got %0d want 0", t, wq.size()); end
        last_rd = ref_read(a, sz);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ref_mem[i] = 8'($urandom);
      ram[i] = ref_mem[i];
    end
    ref_mem[16'h0100] = 8'h12; ref_mem[16'h0101] = 8'h34;
    ref_mem[16'h0102] = 8'h56; ref_mem[16'h0103] = 8'h78;
    for (int i = 16'h0100; i < 16'h0104; i++) ram[i] = ref_mem[i];
    bus.cpu_req = 1'b0;
    bus.cpu_access_type = 1'b0;
    bus.cpu_access_size = 2'd0;
    bus.cpu_addr = 32'h0;
    bus.cpu_wr_data = 32'h0;
    @(negedge clk);
    test_reset();
    test_read32();
    test_write_wrap();
    test_small_sizes();
    test_held_req();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frost32_mem_bridge.md
FROST32_MEM_BRIDGE -- requirements
Module: frost32_mem_bridge

Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 16, byte-address width of memory port; CPU addresses are masked to this width.
REQ-002 SHALL have one clock and a synchronous, active-low reset.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cpu_req  in  1  request mem access (req_mem_access)
- cpu_addr  in  32  byte address of first byte
- cpu_wr_data  in  32  write data, right-justified for 8/16-bit sizes
- cpu_access_type  in  1  0 = read, 1 = write
- cpu_access_size  in  2  0 = 32-bit, 1 = 16-bit, 2 = 8-bit, 3 = reserved (treated as 32-bit)
- cpu_rd_data  out  32  read result, zero-extended
- cpu_busy  out  1  access in progress, request not accepted
- cpu_done  out  1  one-cycle pulse, access complete
- mem_addr  out  ADDR_WIDTH  byte address to 8-bit synchronous RAM
- mem_wr_en  out  1  byte write strobe
- mem_wr_data  out  8  byte to write
- mem_rd_data  in  8  RAM read byte, valid one cycle after mem_addr presented

Function
REQ-004 SHALL implement FSM states IDLE, READ, WRITE, DONE; all outputs registered.
REQ-005 In IDLE, cpu_req high at a rising edge SHALL latch addr, wr_data, type and size, set byte count n (4/2/1), and enter READ or WRITE; cpu_req SHALL be ignored in every other state.
REQ-006 Byte i (i = 0..n-1) SHALL use address (cpu_addr + i) mod 2^ADDR_WIDTH; 0xFFFF+1 wraps to 0x0000 at ADDR_WIDTH=16.
REQ-007 Byte order SHALL be big-endian: byte 0 is the most-significant byte of the n-byte value.
REQ-008 WRITE SHALL last n cycles; in cycle i after acceptance (i = 1..n) it SHALL drive mem_wr_en=1, mem_addr = byte i-1 address, mem_wr_data = byte i-1 of the latched data; then DONE.
REQ-009 READ SHALL last n+1 cycles; it SHALL present byte i address in cycle i+1 after acceptance with mem_wr_en=0, and shift mem_rd_data into an accumulator at the edge that ends each of cycles 2..n+1; then DONE.
REQ-010 On entry to DONE after READ, cpu_rd_data SHALL hold the n-byte value zero-extended to 32 bits; it SHALL be held unchanged until the next READ completes, and WRITE SHALL not alter it.
REQ-011 DONE SHALL last exactly one cycle with cpu_done=1, then IDLE; cpu_done SHALL be 0 in all other states.
REQ-012 cpu_busy SHALL be 1 in READ, WRITE and DONE and 0 in IDLE; a request held across DONE SHALL be accepted at the first edge in IDLE.
REQ-013 Latency from the acceptance edge to cpu_done SHALL be: read 32/16/8 = 6/4/3 cycles; write 32/16/8 = 5/3/2 cycles.
REQ-014 mem_wr_en SHALL be 0 outside WRITE; mem_addr and mem_wr_data SHALL hold their last values when idle.
REQ-015 Changes on cpu_addr, cpu_wr_data, cpu_access_type or cpu_access_size after acceptance SHALL not affect the access in progress.

Reset
REQ-016 rst_n=0 at a rising edge SHALL force IDLE and drive cpu_rd_data, cpu_busy, cpu_done, mem_addr, mem_wr_en, mem_wr_data and the accumulator to 0.
REQ-017 Reset during READ or WRITE SHALL abort the access; bytes already written stay written, no further mem_wr_en is issued, and no cpu_done is produced.
REQ-018 Reset SHALL take priority over a simultaneous cpu_req.

Verification
REQ-019 RAM[0x0100..0x0103] = 12 34 56 78, 32-bit read at 0x0100 -> cpu_done 6 cycles after acceptance, cpu_rd_data = 0x12345678, mem_addr sequence 0100, 0101, 0102, 0103.
REQ-020 32-bit write of 0xDEADBEEF at 0xFFFE -> writes DE@FFFE, AD@FFFF, BE@0000, EF@0001, cpu_done at 5 cycles; a read-back returns 0xDEADBEEF.
REQ-021 16-bit read at 0x0102 -> 0x00005678 at 4 cycles; 8-bit write of 0x000000A5 at 0x0010 -> single strobe, A5@0010, done at 2 cycles.
REQ-022 Hold cpu_req high with changing cpu_addr during a 32-bit read -> no second access starts before IDLE; latched address is used throughout; the next access is accepted in the cycle after DONE.
REQ-023 Assert rst_n=0 in the 2nd byte of a 32-bit write -> only byte 0 is written, all outputs are 0 the next cycle, and no cpu_done occurs.
REQ-024 Reserved size 3 read at 0x0100 -> behaves as a 32-bit read and returns 0x12345678.
